// File: rtl/reg_pc_pkg.sv
// Shared pipeline-register constants: program-counter width and the
// default address the fetch stage restarts from after reset.
package reg_pc_pkg;

  // Architectural program-counter width in bits.
  localparam int DEFAULT_XLEN = 32;

  // Address the fetch PC takes while reset is asserted.
  localparam logic [DEFAULT_XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage : reg_pc_pkg

// File: rtl/reg_pc.sv
// Fetch-stage program-counter register.
// PCF is a plain flop bank: reset forces the restart vector, a fetch stall
// holds the current address, otherwise the next-PC mux output is loaded
// verbatim with one cycle of latency.
module reg_pc
  import reg_pc_pkg::*;
#(
  parameter int              XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            StallF,
  input  logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCF
);

  // PC register update: reset beats stall, stall beats load.
  // NOTE: reset is sampled on the clock edge only, so it stays out of the
  // sensitivity list; non-blocking assignment keeps the flop race-free.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      PCF <= RESET_VECTOR;
    end else if (!StallF) begin
      PCF <= PC;
    end
  end

  // Simulation-only checks of the register's contract.

  // Right after a reset edge the PC must be a clean, known address.
  a_known_after_reset : assert property (
    @(posedge CLK) RESET |=> !$isunknown(PCF)
  ) else $error("reg_pc: PCF unknown after reset edge");

  // A stalled edge must leave the PC untouched.
  a_hold_on_stall : assert property (
    @(posedge CLK) (!RESET && StallF) |=> (PCF == $past(PCF))
  ) else $error("reg_pc: PCF changed across a stalled edge");

  // An unstalled edge must capture the incoming next-PC exactly.
  a_load_on_run : assert property (
    @(posedge CLK) (!RESET && !StallF) |=> (PCF == $past(PC))
  ) else $error("reg_pc: PCF did not load PC");

endmodule : reg_pc

// File: tb/tb_reg_pc.sv
// Self-checking bench for reg_pc.
// Two instances share the same stimulus: one with the default restart
// vector and one restarting at 0x8000_0000. A cycle-level reference model
// predicts each instance's PCF, a negedge process compares every cycle, and
// the directed sequence also pins hand-computed literal values.
module tb_reg_pc;

  localparam logic [31:0] RV0 = 32'h0000_0000;
  localparam logic [31:0] RV1 = 32'h8000_0000;

  logic        CLK;
  logic        RESET;
  logic        StallF;
  logic [31:0] PC;
  logic [31:0] pcf0;
  logic [31:0] pcf1;

  int n_vec  = 0;
  int n_fail = 0;

  reg_pc dut0 (
    .CLK    (CLK),
    .RESET  (RESET),
    .StallF (StallF),
    .PC     (PC),
    .PCF    (pcf0)
  );

  reg_pc #(
    .XLEN         (32),
    .RESET_VECTOR (RV1)
  ) dut1 (
    .CLK    (CLK),
    .RESET  (RESET),
    .StallF (StallF),
    .PC     (PC),
    .PCF    (pcf1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the architectural PC of a fetch stage. Its value is
  // meaningful only once a reset edge has been seen.
  logic [31:0] model0;
  logic [31:0] model1;
  bit          model_valid = 1'b0;

  always @(posedge CLK) begin
    if (RESET) begin
      model0      <= RV0;
      model1      <= RV1;
      model_valid <= 1'b1;
    end else if (StallF) begin
      model0 <= model0;
      model1 <= model1;
    end else begin
      model0 <= PC;
      model1 <= PC;
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge CLK) begin
    if (model_valid) begin
      check("model_pcf0", pcf0, model0);
      check("model_pcf1", pcf1, model1);
    end
  end

  // Apply one set of inputs across one rising edge; outputs settle by #1.
  task automatic cyc(input logic rst, input logic stall, input logic [31:0] pc);
    RESET  = rst;
    StallF = stall;
    PC     = pc;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET  = 1'b1;
    StallF = 1'b1;
    PC     = '0;

    // Reset with stall also high: reset wins on the very first edge.
    cyc(1'b1, 1'b1, 32'h0000_0000);
    check("reset_first_edge_pcf0", pcf0, 32'h0000_0000);
    check("reset_first_edge_pcf1", pcf1, 32'h8000_0000);
    // Reset held: PCF stays at the vector while PC wanders (also X).
    cyc(1'b1, 1'b1, 32'hDEAD_BEEF);
    check("reset_hold_pcf0", pcf0, 32'h0000_0000);
    cyc(1'b1, 1'b0, 'x);
    check("reset_x_pc_pcf0", pcf0, 32'h0000_0000);
    check("reset_x_pc_pcf1", pcf1, 32'h8000_0000);
    cyc(1'b1, 1'b0, 32'h0000_0000);

    // Run: PC = PCF + 4 each cycle.
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b0, pcf0 + 32'd4);
      check("run_step", pcf0, 32'(i * 4));
    end
    check("run_at_0x10", pcf0, 32'h0000_0010);

    // Stall for four edges while PC keeps moving (and once goes unknown).
    cyc(1'b0, 1'b1, 32'h0000_0014);
    check("stall_e1", pcf0, 32'h0000_0010);
    cyc(1'b0, 1'b1, 32'h0000_0018);
    check("stall_e2", pcf0, 32'h0000_0010);
    cyc(1'b0, 1'b1, 'x);
    check("stall_e3_xpc", pcf0, 32'h0000_0010);
    cyc(1'b0, 1'b1, 32'h0000_0020);
    check("stall_e4", pcf0, 32'h0000_0010);
    check("stall_e4_pcf1", pcf1, 32'h0000_0010);

    // Release: first unstalled edge loads PC presented at that edge.
    cyc(1'b0, 1'b0, 32'h0000_0014);
    check("release", pcf0, 32'h0000_0014);
    while (pcf0 != 32'h0000_0040 && n_vec < 1000) begin
      cyc(1'b0, 1'b0, pcf0 + 32'd4);
    end
    check("resume_to_0x40", pcf0, 32'h0000_0040);

    // Mid-run reset with a stall pending.
    cyc(1'b1, 1'b1, 32'h0000_0044);
    check("midrun_reset_pcf0", pcf0, 32'h0000_0000);
    check("midrun_reset_pcf1", pcf1, 32'h8000_0000);
    cyc(1'b0, 1'b0, 32'h0000_0004);
    check("after_midrun_load", pcf0, 32'h0000_0004);
    check("after_midrun_load1", pcf1, 32'h0000_0004);

    // Mid-run reset with a load pending, then full-width verbatim load.
    cyc(1'b1, 1'b0, 32'h1234_5678);
    check("reset_beats_load", pcf1, 32'h8000_0000);
    cyc(1'b0, 1'b0, 32'hFFFF_FFFC);
    check("full_width_pcf1", pcf1, 32'hFFFF_FFFC);
    check("full_width_pcf0", pcf0, 32'hFFFF_FFFC);
    // Unaligned / odd values pass through untouched.
    cyc(1'b0, 1'b0, 32'hA5A5_5A5B);
    check("verbatim_odd", pcf0, 32'hA5A5_5A5B);
    cyc(1'b0, 1'b0, 32'h0000_0001);
    check("verbatim_one", pcf0, 32'h0000_0001);

    // Mixed traffic: the every-cycle compare carries the checking here.
    for (int i = 0; i < 40; i++) begin
      cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0), $urandom);
    end

    cyc(1'b0, 1'b0, 32'h0000_0100);
    check("final_load", pcf0, 32'h0000_0100);
    @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_reg_pc
